// File: rtl/alu_arbiter_if.sv
// Requester, response and ALU-side signals of alu_arbiter.
// slave = arbiter side, master = requesters plus the ALU.
interface alu_arbiter_if #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned WIDTH   = 32
) ();
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ-1:0]       req_ready;
   logic [3*NUM_REQ-1:0]     req_func;
   logic [WIDTH*NUM_REQ-1:0] req_op_a;
   logic [WIDTH*NUM_REQ-1:0] req_op_b;
   logic [NUM_REQ-1:0]       rsp_valid;
   logic [NUM_REQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]         rsp_result;
   logic                     rsp_err;
   logic [2:0]               alu_func;
   logic [WIDTH-1:0]         alu_op_1;
   logic [WIDTH-1:0]         alu_op_2;
   logic [WIDTH-1:0]         alu_result;

   modport slave (
      input  req_valid, req_func, req_op_a, req_op_b, rsp_ready, alu_result,
      output req_ready, rsp_valid, rsp_result, rsp_err, alu_func, alu_op_1, alu_op_2
   );

   modport master (
      output req_valid, req_func, req_op_a, req_op_b, rsp_ready, alu_result,
      input  req_ready, rsp_valid, rsp_result, rsp_err, alu_func, alu_op_1, alu_op_2
   );
endinterface

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters with a single op in flight.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module alu_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned WIDTH   = 32
) (
   input  logic         clk,
   input  logic         rst,
   alu_arbiter_if.slave bus
);
   localparam int unsigned IdxW = $clog2(NUM_REQ);

   typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

   state_e             state_q, state_d;
   logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
   logic [IdxW-1:0]    owner_q, owner_d;
   logic [2:0]         alu_func_q, alu_func_d;
   logic [WIDTH-1:0]   alu_op_1_q, alu_op_1_d;
   logic [WIDTH-1:0]   alu_op_2_q, alu_op_2_d;
   logic [WIDTH-1:0]   rsp_result_q, rsp_result_d;
   logic               rsp_err_q, rsp_err_d;
   logic [NUM_REQ-1:0] req_ready, rsp_valid;
   logic [IdxW-1:0]    grant_idx;
   logic               grant_valid;
   logic [IdxW:0]      scan;

   logic [2:0]         func_arr [NUM_REQ];
   logic [WIDTH-1:0]   op_a_arr [NUM_REQ];
   logic [WIDTH-1:0]   op_b_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign func_arr[i] = bus.req_func[3*i +: 3];
      assign op_a_arr[i] = bus.req_op_a[WIDTH*i +: WIDTH];
      assign op_b_arr[i] = bus.req_op_b[WIDTH*i +: WIDTH];
   end

   // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      scan        = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
         if (scan >= (IdxW+1)'(NUM_REQ)) begin
            scan = scan - (IdxW+1)'(NUM_REQ);
         end
         if (!grant_valid && bus.req_valid[scan[IdxW-1:0]]) begin
            grant_valid = 1'b1;
            grant_idx   = scan[IdxW-1:0];
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      owner_d      = owner_q;
      alu_func_d   = alu_func_q;
      alu_op_1_d   = alu_op_1_q;
      alu_op_2_d   = alu_op_2_q;
      rsp_result_d = rsp_result_q;
      rsp_err_d    = rsp_err_q;
      req_ready    = '0;
      rsp_valid    = '0;
      unique case (state_q)
         StIdle: begin
            if (grant_valid) begin
               req_ready[grant_idx] = 1'b1;
               alu_func_d           = func_arr[grant_idx];
               alu_op_1_d           = op_a_arr[grant_idx];
               alu_op_2_d           = op_b_arr[grant_idx];
               owner_d              = grant_idx;
               state_d              = StExec;
            end
         end
         StExec: begin
            rsp_result_d = bus.alu_result;
            rsp_err_d    = alu_func_q[2];
            state_d      = StResp;
         end
         StResp: begin
            rsp_valid[owner_q] = 1'b1;
            if (bus.rsp_ready[owner_q]) begin
               state_d = StIdle;
`ifdef ALU_ARB_FIXED_PRIO_EN
               rr_ptr_d = '0;
`else
               rr_ptr_d = (owner_q == IdxW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
`endif
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         rr_ptr_q     <= '0;
         owner_q      <= '0;
         alu_func_q   <= '0;
         alu_op_1_q   <= '0;
         alu_op_2_q   <= '0;
         rsp_result_q <= '0;
         rsp_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         owner_q      <= owner_d;
         alu_func_q   <= alu_func_d;
         alu_op_1_q   <= alu_op_1_d;
         alu_op_2_q   <= alu_op_2_d;
         rsp_result_q <= rsp_result_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   // Handshake outputs are forced low while reset is asserted.
   assign bus.req_ready  = rst ? '0 : req_ready;
   assign bus.rsp_valid  = rst ? '0 : rsp_valid;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_err    = rsp_err_q;
   assign bus.alu_func   = alu_func_q;
   assign bus.alu_op_1   = alu_op_1_q;
   assign bus.alu_op_2   = alu_op_2_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of arbitration order and ALU results.
module tb_alu_arbiter;
   localparam int unsigned NUM_REQ = 2;
   localparam int unsigned WIDTH   = 32;

   logic        clk = 1'b0;
   logic        rst;
   int          errors = 0;
   int          checks = 0;
   int          pref   = 0;
   logic [1:0]  req_valid;
   logic [2:0]  f [2];
   logic [31:0] a [2];
   logic [31:0] b [2];

   alu_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

   alu_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.req_valid  = req_valid;
   assign bus.req_func   = {f[1], f[0]};
   assign bus.req_op_a   = {a[1], a[0]};
   assign bus.req_op_b   = {b[1], b[0]};
   assign bus.alu_result = alu_ref(bus.alu_func, bus.alu_op_1, bus.alu_op_2);

   function automatic logic [31:0] alu_ref(input logic [2:0] fn, input logic [31:0] x,
                                           input logic [31:0] y);
      case (fn)
         3'd0:    return x + y;
         3'd1:    return x - y;
         3'd2:    return x & y;
         3'd3:    return x | y;
         default: return 32'd0;
      endcase
   endfunction

   // Winner = first valid requester at or above the preferred index, wrapping.
   function automatic int pick(input logic [1:0] v);
      for (int k = 0; k < 2; k++) begin
         if (v[(pref + k) % 2]) return (pref + k) % 2;
      end
      return 0;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
      check({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
      check({tag, "_result"}, 64'(bus.rsp_result), 64'd0);
      check({tag, "_err"}, 64'(bus.rsp_err), 64'd0);
      check({tag, "_alu_func"}, 64'(bus.alu_func), 64'd0);
      check({tag, "_alu_op_1"}, 64'(bus.alu_op_1), 64'd0);
      check({tag, "_alu_op_2"}, 64'(bus.alu_op_2), 64'd0);
   endtask

   // One full transaction from the current req_valid/payloads; hold = RESP stall cycles.
   task automatic serve(input int hold, input bit drop_others);
      int          w;
      logic [1:0]  oh;
      logic [31:0] exp_res;
      logic        exp_err;
      #1;
      w       = pick(req_valid);
      oh      = 2'(1 << w);
      exp_res = alu_ref(f[w], a[w], b[w]);
      exp_err = f[w][2];
      check("grant_ready", 64'(bus.req_ready), 64'(oh));
      @(posedge clk); #1;
      req_valid[w] = 1'b0;
      if (drop_others && $urandom_range(0, 1) == 1) req_valid = 2'b00;
      check("exec_ready", 64'(bus.req_ready), 64'd0);
      check("exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      check("exec_func", 64'(bus.alu_func), 64'(f[w]));
      check("exec_op_1", 64'(bus.alu_op_1), 64'(a[w]));
      check("exec_op_2", 64'(bus.alu_op_2), 64'(b[w]));
      @(posedge clk); #1;
      for (int c = 0; c < hold; c++) begin
         bus.rsp_ready = ~oh;
         #1;
         check("hold_rsp_valid", 64'(bus.rsp_valid), 64'(oh));
         check("hold_result", 64'(bus.rsp_result), 64'(exp_res));
         check("hold_err", 64'(bus.rsp_err), 64'(exp_err));
         check("hold_ready", 64'(bus.req_ready), 64'd0);
         @(posedge clk); #1;
      end
      bus.rsp_ready = oh;
      #1;
      check("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
      check("rsp_result", 64'(bus.rsp_result), 64'(exp_res));
      check("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
      @(posedge clk); #1;
      bus.rsp_ready = 2'b00;
      check("rsp_done", 64'(bus.rsp_valid), 64'd0);
`ifdef ALU_ARB_FIXED_PRIO_EN
      pref = 0;
`else
      pref = (w + 1) % 2;
`endif
   endtask

   initial begin
      rst           = 1'b1;
      req_valid     = 2'b00;
      bus.rsp_ready = 2'b00;
      for (int i = 0; i < 2; i++) begin
         f[i] = 3'd0;
         a[i] = 32'd0;
         b[i] = 32'd0;
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check_reset("reset");

      // Single requester add
      f[0] = 3'd0; a[0] = 32'd5; b[0] = 32'd3; req_valid = 2'b01;
      serve(0, 1'b0);

      // No request: stays idle, ALU inputs hold last issued values
      repeat (2) @(posedge clk);
      #1;
      check("idle_ready", 64'(bus.req_ready), 64'd0);
      check("idle_func", 64'(bus.alu_func), 64'd0);
      check("idle_op_1", 64'(bus.alu_op_1), 64'd5);

      // Simultaneous pair after reset, then another pair
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0; pref = 0;
      f[0] = 3'd1; a[0] = 32'd10;   b[0] = 32'd4;
      f[1] = 3'd3; a[1] = 32'hF0;   b[1] = 32'h0F;
      req_valid = 2'b11;
      serve(0, 1'b0);
      serve(0, 1'b0);
      f[0] = 3'd2; a[0] = 32'hFF00; b[0] = 32'h0FF0;
      f[1] = 3'd0; a[1] = 32'hFFFF_FFFF; b[1] = 32'd2;
      req_valid = 2'b11;
      serve(5, 1'b0);
      serve(0, 1'b0);

      // Unsupported func
      f[1] = 3'b101; a[1] = 32'd7; b[1] = 32'd9; req_valid = 2'b10;
      serve(1, 1'b0);

      // Reset during EXEC drops the op
      f[0] = 3'd0; a[0] = 32'd123; b[0] = 32'd456; req_valid = 2'b01;
      #1;
      check("rst_exec_grant", 64'(bus.req_ready), 64'd1);
      @(posedge clk); #1;
      req_valid = 2'b00;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check_reset("rst_exec");
      pref = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("rst_no_rsp", 64'(bus.rsp_valid), 64'd0);
      end

      // Randomized traffic
      for (int n = 0; n < 16; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (!req_valid[i]) begin
               f[i] = 3'($urandom_range(0, 7));
               a[i] = $urandom;
               b[i] = $urandom;
            end
         end
         req_valid = req_valid | 2'($urandom_range(1, 3));
         serve($urandom_range(0, 2), 1'b1);
      end

      // Both continuously valid for six ops
      req_valid = 2'b00;
      f[0] = 3'd0; a[0] = 32'd100; b[0] = 32'd1;
      f[1] = 3'd1; a[1] = 32'd100; b[1] = 32'd1;
      for (int n = 0; n < 6; n++) begin
         req_valid = 2'b11;
         serve(0, 1'b0);
      end
      req_valid = 2'b00;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
